floating_point_add_pipe: RTL and testbench
==========================================

Name: floating_point_add_pipe

Overview:
Pipelined, parametrised IEEE-754 adder/subtractor with a valid/ready stream interface, a per-transaction rounding mode and an opaque tag.
It has a fixed 3-stage pipeline:
- S1: unpack, compare, align.
- S2: add, leading-zero count, normalise.
- S3: round, pack, special-case select.

It also keeps a sticky exception-flag register. It sits between the FPU issue queue and writeback. It is the streaming successor to the combinational two-path adder.

Parameters:
exp_width, 8, exponent field width (must be >= 3).
frac_width, 23, stored fraction width (must be >= 2).
tag_width, 4, width of the tag carried unchanged from input to output (must be >= 1).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block accepts a beat this cycle.
in_op1  input  exp_width+frac_width+1  operand A {sign, exp, frac}.
in_op2  input  exp_width+frac_width+1  operand B.
in_sub  input  1  1 = A - B (B sign inverted before processing), 0 = A + B.
in_round_mode  input  2  rounding mode, encoded per `FP_ROUND_* in FloatingPointConsts.svh.
in_tag  input  tag_width  user tag.
out_valid  output  1  result beat valid.
out_ready  input  1  consumer accepts result.
out_result  output  exp_width+frac_width+1  packed result.
out_exception  output  5  per-result flags; bit positions per `FP_* constants.
out_tag  output  tag_width  tag of this result.
flags_sticky  output  5  OR of out_exception over all results accepted since reset or clear.
flags_clear  input  1  clears flags_sticky.

Behaviour:
- Reset (rst_n low at a clock edge):
  - All stage valid bits := 0 and flags_sticky := 0.
  - out_result, out_exception and out_tag := 0.
  - Data registers need no reset.
  - In-flight beats are dropped. in_ready = 1 in the first cycle after reset.
- Handshake and stall:
  - advance = !out_valid || out_ready; in_ready = advance, purely combinational from registered state and out_ready.
  - When advance = 1, all three stages shift by one.
  - When advance = 0, every stage register holds. The stall is global and bubbles are not squeezed.
  - An input beat is accepted iff in_valid && in_ready. An output beat is accepted iff out_valid && out_ready.
- Latency and ordering:
  - Latency is exactly 3 cycles from acceptance to out_valid when out_ready is held at 1.
  - Throughput is 1 beat/cycle. Order is preserved.
  - out_* stay stable while out_valid && !out_ready.
- Arithmetic:
  - Full IEEE-754 addition, including subnormal inputs and subnormal (gradual-underflow) outputs.
  - Guard, round and sticky bits are kept through alignment. The sticky bit is the OR of all bits shifted out.
  - Alignment shift saturates at frac_width+3.
  - Rounding applies the beat's own in_round_mode.
  - Rounding carry increments the exponent. A carry into exponent all-ones overflows.
- Special cases (priority order):
  1. Either operand NaN: return op1 if it is a NaN, else op2, with the quiet bit (frac MSB) set. A signalling NaN raises invalid.
  2. inf + (-inf) after applying in_sub: return {1, all-ones exp, 1, zeros}; raises invalid.
  3. Any other inf: return inf with the inf operand's sign.
  4. Exact zero sum: +0, except -0 under ROUND_DOWNWARD or when both effective signs are negative.
  5. Overflow: per mode. TONEAREST gives ±inf. TOWARDZERO gives ±MAX. UPWARD gives +inf or -MAX. DOWNWARD gives -inf or +MAX. Raises overflow and inexact.
- Flags:
  - inexact is set when any discarded bit is nonzero.
  - underflow is set when the result is tiny (exponent field 0) AND inexact.
  - The other flag bits are always 0.
- Sticky flags:
  - On a cycle with an output accept and flags_clear both, the new value is the accepted out_exception only; clear applies first, then OR.
  - flags_clear alone sets flags_sticky to 0.

Test Plan:
- 1.0 + 2.0 (0x3F800000, 0x40000000), RNE, out_ready = 1 -> 0x40400000 with out_valid exactly 3 cycles after accept; exception 0; tag echoed.
- in_sub = 1, 1.0 - 1.0 under RNE -> 0x00000000; under DOWNWARD -> 0x80000000. Same stimulus with in_sub = 0 and op2 = 0xBF800000 gives identical results.
- 0x7F7FFFFF + 0x7F7FFFFF: RNE -> 0x7F800000 with overflow and inexact; TOWARDZERO -> 0x7F7FFFFF. Then 0x7F800000 - 0x7F800000 -> 0xFFC00000 with invalid. Smallest subnormals 0x00000001 + 0x00000001 -> 0x00000002, no flags.
- Stream 8 beats back-to-back with tags 0..7 while out_ready toggles 1,0,0,1,...:
  - Results appear in tag order with no loss or duplication.
  - in_ready = 0 exactly when out_valid && !out_ready.
  - out_* are stable during the stall.
- Sticky flags: after an inexact result (1.0 + 0x33800001), flags_sticky has the inexact bit set. Asserting flags_clear in the same cycle as the next accept (an exact result) leaves 0.
- Pull rst_n low for one cycle with 3 beats in flight -> out_valid = 0 next cycle, no stale results emitted, flags_sticky = 0, in_ready = 1.

Source files
------------

// File: rtl/floating_point_add_pipe_if.sv
// Valid/ready stream bundle between the FPU issue queue, the pipelined adder and writeback.
// master = producer/consumer side, slave = the adder.
interface floating_point_add_pipe_if #(
  parameter int exp_width  = 8,
  parameter int frac_width = 23,
  parameter int tag_width  = 4
);
  localparam int width = exp_width + frac_width + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [width-1:0]     in_op1;
  logic [width-1:0]     in_op2;
  logic                 in_sub;
  logic [1:0]           in_round_mode;
  logic [tag_width-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [width-1:0]     out_result;
  logic [4:0]           out_exception;
  logic [tag_width-1:0] out_tag;

  modport master (
    output in_valid, in_op1, in_op2, in_sub, in_round_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_exception, out_tag
  );

  modport slave (
    input  in_valid, in_op1, in_op2, in_sub, in_round_mode, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_exception, out_tag
  );
endinterface

// File: rtl/floating_point_add_pipe.sv
// Three-stage IEEE-754 adder/subtractor: align, add/normalise, round/pack.
// Global stall: every stage holds while the output beat is not taken.
module floating_point_add_pipe #(
  parameter int exp_width  = 8,
  parameter int frac_width = 23,
  parameter int tag_width  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  floating_point_add_pipe_if.slave  stream,
  input  logic                      flags_clear,
  output logic [4:0]                flags_sticky
);
  localparam int width = exp_width + frac_width + 1;
  localparam int ef    = exp_width + frac_width;
  localparam int mw    = frac_width + 4;
  localparam int sw    = $clog2(mw + 1);

  localparam logic [1:0] rm_nearest = 2'd0;
  localparam logic [1:0] rm_zero    = 2'd1;
  localparam logic [1:0] rm_down    = 2'd2;
  localparam logic [1:0] rm_up      = 2'd3;

  localparam int flag_nx = 0;
  localparam int flag_uf = 1;
  localparam int flag_of = 2;
  localparam int flag_nv = 4;

  localparam logic [ef-1:0] inf_mag = {{exp_width{1'b1}}, {frac_width{1'b0}}};
  localparam logic [ef-1:0] max_mag = {{(exp_width-1){1'b1}}, 1'b0, {frac_width{1'b1}}};

  function automatic logic [sw-1:0] count_lz(input logic [mw-1:0] v);
    count_lz = sw'(mw);
    for (int i = 0; i < mw; i++)
      if (v[i]) count_lz = sw'(mw - 1 - i);
  endfunction

  logic advance;
  assign advance         = !stream.out_valid || stream.out_ready;
  assign stream.in_ready = advance;

  logic s1_valid, s2_valid;

  logic                 a_sign, b_sign, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap;
  logic [exp_width-1:0] a_exp, b_exp, big_field, small_field, big_e, small_e, exp_diff;
  logic [frac_width-1:0] a_frac, b_frac;
  logic [mw-1:0]        big_man, small_man, shifted, lost_mask, aligned;
  logic [sw-1:0]        shamt;
  logic                 spec_hit;
  logic [width-1:0]     spec_res, qnan;
  logic [4:0]           spec_flags;

  always_comb begin
    a_sign      = stream.in_op1[width-1];
    a_exp       = stream.in_op1[ef-1:frac_width];
    a_frac      = stream.in_op1[frac_width-1:0];
    b_sign      = stream.in_op2[width-1] ^ stream.in_sub;
    b_exp       = stream.in_op2[ef-1:frac_width];
    b_frac      = stream.in_op2[frac_width-1:0];
    a_nan       = (&a_exp) && (|a_frac);
    b_nan       = (&b_exp) && (|b_frac);
    a_snan      = a_nan && !a_frac[frac_width-1];
    b_snan      = b_nan && !b_frac[frac_width-1];
    a_inf       = (&a_exp) && !(|a_frac);
    b_inf       = (&b_exp) && !(|b_frac);
    swap        = stream.in_op2[ef-1:0] > stream.in_op1[ef-1:0];
    big_field   = swap ? b_exp : a_exp;
    small_field = swap ? a_exp : b_exp;
    big_man     = {|big_field, swap ? b_frac : a_frac, 3'b000};
    small_man   = {|small_field, swap ? a_frac : b_frac, 3'b000};
    // Subnormals share the exponent of the smallest normal.
    big_e       = (big_field == '0) ? exp_width'(1) : big_field;
    small_e     = (small_field == '0) ? exp_width'(1) : small_field;
    exp_diff    = big_e - small_e;
    shamt       = (int'(exp_diff) > frac_width + 3) ? sw'(frac_width + 3) : sw'(exp_diff);
    lost_mask   = ~({mw{1'b1}} << shamt);
    shifted     = small_man >> shamt;
    aligned     = {shifted[mw-1:1], shifted[0] | (|(small_man & lost_mask))};

    spec_hit   = 1'b0;
    spec_res   = '0;
    spec_flags = '0;
    qnan       = a_nan ? stream.in_op1 : stream.in_op2;
    qnan[frac_width-1] = 1'b1;
    if (a_nan || b_nan) begin
      spec_hit            = 1'b1;
      spec_res            = qnan;
      spec_flags[flag_nv] = a_snan || b_snan;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      spec_hit            = 1'b1;
      spec_res            = {1'b1, {exp_width{1'b1}}, 1'b1, {(frac_width-1){1'b0}}};
      spec_flags[flag_nv] = 1'b1;
    end else if (a_inf) begin
      spec_hit = 1'b1;
      spec_res = {a_sign, inf_mag};
    end else if (b_inf) begin
      spec_hit = 1'b1;
      spec_res = {b_sign, inf_mag};
    end
  end

  logic                 s1_sign, s1_sub, s1_both_neg, s1_spec_hit;
  logic [exp_width-1:0] s1_exp;
  logic [mw-1:0]        s1_ma, s1_mb;
  logic [1:0]           s1_rm;
  logic [tag_width-1:0] s1_tag;
  logic [width-1:0]     s1_spec_res;
  logic [4:0]           s1_spec_flags;

  logic [mw:0]          sum;
  logic [sw-1:0]        lz, lshift;
  logic [exp_width-1:0] exp_lim, norm_exp;
  logic [mw-1:0]        norm;

  always_comb begin
    sum      = s1_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb}) : ({1'b0, s1_ma} + {1'b0, s1_mb});
    lz       = count_lz(sum[mw-1:0]);
    exp_lim  = s1_exp - exp_width'(1);
    // Never normalise below the minimum exponent; what remains is subnormal.
    lshift   = (int'(lz) > int'(exp_lim)) ? sw'(exp_lim) : lz;
    norm     = '0;
    norm_exp = '0;
    if (sum[mw]) begin
      norm     = {sum[mw:2], sum[1] | sum[0]};
      norm_exp = s1_exp + exp_width'(1);
    end else begin
      norm     = sum[mw-1:0] << lshift;
      norm_exp = norm[mw-1] ? (s1_exp - exp_width'(lshift)) : '0;
    end
  end

  logic                 s2_sign, s2_zero, s2_both_neg, s2_spec_hit;
  logic [exp_width-1:0] s2_exp;
  logic [mw-2:0]        s2_man;
  logic [1:0]           s2_rm;
  logic [tag_width-1:0] s2_tag;
  logic [width-1:0]     s2_spec_res;
  logic [4:0]           s2_spec_flags;

  logic             guard, rest, inexact, round_up, overflow, tiny;
  logic [ef:0]      rounded;
  logic [width-1:0] res;
  logic [4:0]       flags;

  always_comb begin
    guard    = s2_man[2];
    rest     = s2_man[1] | s2_man[0];
    inexact  = guard | rest;
    round_up = 1'b0;
    case (s2_rm)
      rm_nearest: round_up = guard && (rest || s2_man[3]);
      rm_zero:    round_up = 1'b0;
      rm_down:    round_up = inexact && s2_sign;
      rm_up:      round_up = inexact && !s2_sign;
      default:    round_up = 1'b0;
    endcase
    // The increment ripples into the exponent field, covering mantissa carry and subnormal-to-normal.
    rounded  = {1'b0, s2_exp, s2_man[mw-2:3]} + (ef + 1)'(round_up);
    overflow = (&s2_exp) || (&rounded[ef-1:frac_width]) || rounded[ef];
    tiny     = rounded[ef-1:frac_width] == '0;

    res            = {s2_sign, rounded[ef-1:0]};
    flags          = '0;
    flags[flag_nx] = inexact;
    flags[flag_uf] = tiny && inexact;
    if (s2_spec_hit) begin
      res   = s2_spec_res;
      flags = s2_spec_flags;
    end else if (s2_zero) begin
      res   = {(s2_rm == rm_down) || s2_both_neg, {ef{1'b0}}};
      flags = '0;
    end else if (overflow) begin
      flags          = '0;
      flags[flag_of] = 1'b1;
      flags[flag_nx] = 1'b1;
      case (s2_rm)
        rm_nearest: res = {s2_sign, inf_mag};
        rm_zero:    res = {s2_sign, max_mag};
        rm_up:      res = {s2_sign, s2_sign ? max_mag : inf_mag};
        rm_down:    res = {s2_sign, s2_sign ? inf_mag : max_mag};
        default:    res = {s2_sign, inf_mag};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign       <= swap ? b_sign : a_sign;
      s1_sub        <= a_sign != b_sign;
      s1_both_neg   <= a_sign && b_sign;
      s1_exp        <= big_e;
      s1_ma         <= big_man;
      s1_mb         <= aligned;
      s1_rm         <= stream.in_round_mode;
      s1_tag        <= stream.in_tag;
      s1_spec_hit   <= spec_hit;
      s1_spec_res   <= spec_res;
      s1_spec_flags <= spec_flags;
      s2_sign       <= s1_sign;
      s2_zero       <= sum == '0;
      s2_both_neg   <= s1_both_neg;
      s2_exp        <= norm_exp;
      s2_man        <= norm[mw-2:0];
      s2_rm         <= s1_rm;
      s2_tag        <= s1_tag;
      s2_spec_hit   <= s1_spec_hit;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
    end
  end

  // Clear takes effect before the accepted beat's flags are merged in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid             <= 1'b0;
      s2_valid             <= 1'b0;
      stream.out_valid     <= 1'b0;
      stream.out_result    <= '0;
      stream.out_exception <= '0;
      stream.out_tag       <= '0;
      flags_sticky         <= '0;
    end else begin
      if (advance) begin
        s1_valid             <= stream.in_valid;
        s2_valid             <= s1_valid;
        stream.out_valid     <= s2_valid;
        stream.out_result    <= res;
        stream.out_exception <= flags;
        stream.out_tag       <= s2_tag;
      end
      flags_sticky <= (flags_clear ? 5'b0 : flags_sticky) |
                      ((stream.out_valid && stream.out_ready) ? stream.out_exception : 5'b0);
    end
  end
endmodule

// File: tb/tb_floating_point_add_pipe.sv
// Directed single-precision vectors, a stalled stream, sticky flags and reset with beats in flight.
module tb_floating_point_add_pipe;
  localparam logic [1:0] rm_nearest = 2'd0;
  localparam logic [1:0] rm_zero    = 2'd1;
  localparam logic [1:0] rm_down    = 2'd2;
  localparam logic [1:0] rm_up      = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flags_clear;
  logic [4:0] flags_sticky;
  int         total_count = 0;
  int         bad_count = 0;

  logic [31:0] stream_op2 [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h00000000};
  logic [31:0] stream_exp [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                                  32'h40C00000, 32'h40E00000, 32'h41000000, 32'h3F800000};

  floating_point_add_pipe_if #(.exp_width(8), .frac_width(23), .tag_width(4)) ifc ();

  floating_point_add_pipe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stream       (ifc.slave),
    .flags_clear  (flags_clear),
    .flags_sticky (flags_sticky)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    total_count++;
    if (got !== want) begin
      bad_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] op1, input logic [31:0] op2, input logic sub,
                               input logic [1:0] rm, input logic [3:0] tag);
    ifc.in_valid      = 1'b1;
    ifc.in_op1        = op1;
    ifc.in_op2        = op2;
    ifc.in_sub        = sub;
    ifc.in_round_mode = rm;
    ifc.in_tag        = tag;
  endtask

  task automatic runOne(input string name, input logic [31:0] op1, input logic [31:0] op2,
                        input logic sub, input logic [1:0] rm, input logic [3:0] tag,
                        input logic [31:0] want_res, input logic [4:0] want_exc, input logic clear_at_out);
    int lat;
    applyStimulus(op1, op2, sub, rm, tag);
    checkOutput({name, "_rdy"}, 64'(ifc.in_ready), 64'd1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    lat = 1;
    while (!ifc.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, "_lat"}, 64'(lat), 64'd3);
    checkOutput({name, "_res"}, 64'(ifc.out_result), 64'(want_res));
    checkOutput({name, "_exc"}, 64'(ifc.out_exception), 64'(want_exc));
    checkOutput({name, "_tag"}, 64'(ifc.out_tag), 64'(tag));
    if (clear_at_out) begin
      flags_clear = 1'b1;
      @(posedge clk); #1;
      flags_clear = 1'b0;
    end
  endtask

  initial begin
    int          tx, rx, cyc;
    logic        stalled_prev, seen;
    logic [31:0] held_res;
    logic [3:0]  held_tag;

    rst_n = 1'b0;
    flags_clear = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_op1 = '0;
    ifc.in_op2 = '0;
    ifc.in_sub = 1'b0;
    ifc.in_round_mode = rm_nearest;
    ifc.in_tag = '0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    checkOutput("rst_sticky", 64'(flags_sticky), 64'd0);
    checkOutput("rst_result", 64'(ifc.out_result), 64'd0);
    checkOutput("rst_exc", 64'(ifc.out_exception), 64'd0);
    checkOutput("rst_tag", 64'(ifc.out_tag), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    runOne("add12",   32'h3F800000, 32'h40000000, 1'b0, rm_nearest, 4'hA, 32'h40400000, 5'h00, 1'b0);
    runOne("sub_rne", 32'h3F800000, 32'h3F800000, 1'b1, rm_nearest, 4'h1, 32'h00000000, 5'h00, 1'b0);
    runOne("sub_rdn", 32'h3F800000, 32'h3F800000, 1'b1, rm_down,    4'h2, 32'h80000000, 5'h00, 1'b0);
    runOne("neg_rne", 32'h3F800000, 32'hBF800000, 1'b0, rm_nearest, 4'h3, 32'h00000000, 5'h00, 1'b0);
    runOne("neg_rdn", 32'h3F800000, 32'hBF800000, 1'b0, rm_down,    4'h4, 32'h80000000, 5'h00, 1'b0);
    runOne("norm_sub",32'h3FC00000, 32'h3F800000, 1'b1, rm_nearest, 4'h5, 32'h3F000000, 5'h00, 1'b0);
    runOne("ovf_rne", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, rm_nearest, 4'h6, 32'h7F800000, 5'h05, 1'b0);
    runOne("ovf_rtz", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, rm_zero,    4'h7, 32'h7F7FFFFF, 5'h05, 1'b0);
    runOne("ovf_rdn", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, rm_down,    4'h8, 32'h7F7FFFFF, 5'h05, 1'b0);
    runOne("ovf_rup", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, rm_up,      4'h9, 32'h7F800000, 5'h05, 1'b0);
    runOne("inf_inf", 32'h7F800000, 32'h7F800000, 1'b1, rm_nearest, 4'hB, 32'hFFC00000, 5'h10, 1'b0);
    runOne("subnorm", 32'h00000001, 32'h00000001, 1'b0, rm_nearest, 4'hC, 32'h00000002, 5'h00, 1'b0);
    runOne("snan",    32'h7F800001, 32'h3F800000, 1'b0, rm_nearest, 4'hD, 32'h7FC00001, 5'h10, 1'b0);
    runOne("tie_rne", 32'h3F800000, 32'h33800000, 1'b0, rm_nearest, 4'hE, 32'h3F800000, 5'h01, 1'b0);
    runOne("tie_rup", 32'h3F800000, 32'h33800000, 1'b0, rm_up,      4'hF, 32'h3F800001, 5'h01, 1'b0);

    // Back-to-back stream with out_ready following 1,0,0,1,0,0,...
    tx = 0;
    rx = 0;
    cyc = 0;
    stalled_prev = 1'b0;
    held_res = '0;
    held_tag = '0;
    while (rx < 8 && cyc < 200) begin
      @(posedge clk); #1;
      ifc.out_ready = (cyc % 3 == 0);
      if (tx < 8) applyStimulus(32'h3F800000, stream_op2[tx], 1'b0, rm_nearest, 4'(tx));
      else ifc.in_valid = 1'b0;
      #1;
      if (stalled_prev) begin
        checkOutput("stall_res", 64'(ifc.out_result), 64'(held_res));
        checkOutput("stall_tag", 64'(ifc.out_tag), 64'(held_tag));
      end
      checkOutput("stream_in_ready", 64'(ifc.in_ready), 64'(!(ifc.out_valid && !ifc.out_ready)));
      stalled_prev = ifc.out_valid && !ifc.out_ready;
      held_res = ifc.out_result;
      held_tag = ifc.out_tag;
      if (ifc.out_valid && ifc.out_ready) begin
        checkOutput("stream_res", 64'(ifc.out_result), 64'(stream_exp[rx]));
        checkOutput("stream_tag", 64'(ifc.out_tag), 64'(rx));
        rx++;
      end
      if (ifc.in_valid && ifc.in_ready) tx++;
      cyc++;
    end
    checkOutput("stream_count", 64'(rx), 64'd8);
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;

    flags_clear = 1'b1;
    @(posedge clk); #1;
    flags_clear = 1'b0;
    checkOutput("sticky_cleared", 64'(flags_sticky), 64'd0);
    runOne("inexact", 32'h3F800000, 32'h33800001, 1'b0, rm_nearest, 4'h3, 32'h3F800001, 5'h01, 1'b0);
    @(posedge clk); #1;
    checkOutput("sticky_nx", 64'(flags_sticky), 64'h01);
    runOne("exact_clr", 32'h3F800000, 32'h40000000, 1'b0, rm_nearest, 4'h4, 32'h40400000, 5'h00, 1'b1);
    checkOutput("sticky_clr_acc", 64'(flags_sticky), 64'd0);

    // Reset with three beats held in the stalled pipeline.
    runOne("ovf_again", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, rm_nearest, 4'h5, 32'h7F800000, 5'h05, 1'b0);
    @(posedge clk); #1;
    checkOutput("sticky_of", 64'(flags_sticky), 64'h05);
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h3F800000, 32'h40000000, 1'b0, rm_nearest, 4'(8 + i));
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    checkOutput("full_out_valid", 64'(ifc.out_valid), 64'd1);
    checkOutput("full_in_ready", 64'(ifc.in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("rr_out_valid", 64'(ifc.out_valid), 64'd0);
    checkOutput("rr_in_ready", 64'(ifc.in_ready), 64'd1);
    checkOutput("rr_sticky", 64'(flags_sticky), 64'd0);
    checkOutput("rr_tag", 64'(ifc.out_tag), 64'd0);
    ifc.out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ifc.out_valid) seen = 1'b1;
    end
    checkOutput("rr_no_stale", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end
endmodule
